// File: rtl/score_keeper.sv
// Game-state and score engine: counts frames from VGA vsync, keeps a 3-digit BCD
// score and high score, and exposes CTRL/STATUS/SCORE/FPP registers to the HPS bus.
module score_keeper #(
  parameter int unsigned FRAMES_PER_POINT = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        vsync_n,
  input  logic        collision,
  output logic [3:0]  score_d0,
  output logic [3:0]  score_d1,
  output logic [3:0]  score_d2,
  output logic [3:0]  hi_d0,
  output logic [3:0]  hi_d1,
  output logic [3:0]  hi_d2,
  output logic        running,
  output logic        game_over,
  output logic [1:0]  state_dbg
);

  // Bus handshake: a write acts on the edge where chipselect & write is high; a read
  // is captured into readdata on the edge where chipselect & read is high and is held.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [7:0] FPP_RST = 8'(FRAMES_PER_POINT);

  state_t      state_q, state_d;
  logic [11:0] score_q, score_d;
  logic [11:0] hi_q, hi_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [7:0]  fpp_q, fpp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        vsync_d_q, vsync_d_d;

  logic        wr_en, rd_en, tick;
  logic        cmd_start, cmd_pause, cmd_resume, cmd_clrhi;
  logic [7:0]  fpp_eff;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:8];

  // BCD increment with saturation at 999.
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] d0, d1, d2;
    d0 = v[3:0];
    d1 = v[7:4];
    d2 = v[11:8];
    if (v == 12'h999) begin
      return v;
    end
    if (d0 == 4'd9) begin
      d0 = 4'd0;
      if (d1 == 4'd9) begin
        d1 = 4'd0;
        d2 = d2 + 4'd1;
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
    return {d2, d1, d0};
  endfunction

  always_comb begin
    wr_en      = chipselect & write;
    rd_en      = chipselect & read;
    cmd_start  = wr_en && (address == 2'd0) && writedata[0];
    cmd_pause  = wr_en && (address == 2'd0) && writedata[1];
    cmd_resume = wr_en && (address == 2'd0) && writedata[2];
    cmd_clrhi  = wr_en && (address == 2'd0) && writedata[3];
    tick       = vsync_n & ~vsync_d_q;
    fpp_eff    = (fpp_q == 8'd0) ? 8'd1 : fpp_q;
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    hi_d        = hi_q;
    frame_cnt_d = frame_cnt_q;
    fpp_d       = fpp_q;
    rdata_d     = rdata_q;
    vsync_d_d   = vsync_n;

    if (cmd_start) begin
      state_d     = ST_RUN;
      score_d     = 12'h000;
      frame_cnt_d = 8'd0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          // A hit wins over both PAUSE and a coincident frame tick.
          if (collision) begin
            state_d = ST_OVER;
            if (score_q > hi_q) begin
              hi_d = score_q;
            end
          end else begin
            if (cmd_pause) begin
              state_d = ST_PAUSE;
            end
            if (tick) begin
              if (frame_cnt_q == fpp_eff - 8'd1) begin
                frame_cnt_d = 8'd0;
                score_d     = bcd_inc(score_q);
              end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (cmd_resume) begin
            state_d = ST_RUN;
          end
        end
        default: begin
        end
      endcase
    end

    if (cmd_clrhi) begin
      hi_d = 12'h000;
    end

    if (wr_en && (address == 2'd3)) begin
      fpp_d = writedata[7:0];
    end

    if (rd_en) begin
      unique case (address)
        2'd0:    rdata_d = 32'd0;
        2'd1:    rdata_d = {29'd0, collision, state_q};
        2'd2:    rdata_d = {8'd0, hi_q, score_q};
        default: rdata_d = {24'd0, fpp_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      score_q     <= 12'h000;
      hi_q        <= 12'h000;
      frame_cnt_q <= 8'd0;
      fpp_q       <= FPP_RST;
      rdata_q     <= 32'd0;
      vsync_d_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hi_q        <= hi_d;
      frame_cnt_q <= frame_cnt_d;
      fpp_q       <= fpp_d;
      rdata_q     <= rdata_d;
      vsync_d_q   <= vsync_d_d;
    end
  end

  assign readdata  = rdata_q;
  assign score_d0  = score_q[3:0];
  assign score_d1  = score_q[7:4];
  assign score_d2  = score_q[11:8];
  assign hi_d0     = hi_q[3:0];
  assign hi_d1     = hi_q[7:4];
  assign hi_d2     = hi_q[11:8];
  assign running   = (state_q == ST_RUN);
  assign game_over = (state_q == ST_OVER);
  assign state_dbg = state_q;

endmodule
